// File: rtl/player_motion_pkg.sv
// player_motion_pkg: shared state encodings and ctrl_in bit positions
// for the per-player motion engine (player_motion_fsm).
package player_motion_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_CROUCH = 3'd2,
    ST_AIR    = 3'd3,
    ST_ATTACK = 3'd4,
    ST_SHIELD = 3'd5
  } motion_state_t;

  localparam int CTRL_W      = 7;
  localparam int CTRL_DOWN   = 1;
  localparam int CTRL_RIGHT  = 2;
  localparam int CTRL_UP     = 3;
  localparam int CTRL_LEFT   = 4;
  localparam int CTRL_ATTACK = 5;
  localparam int CTRL_SHIELD = 6;

endpackage

// File: rtl/motion_tick_timer.sv
// motion_tick_timer: loadable down-counter advanced by a tick strobe.
// Ports: clk, rst (sync, active-high), tick, load, value -> count, zero.
module motion_tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      if (load) begin
        count <= value;
      end else if (count != '0) begin
        count <= count - W'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_motion_fsm.sv
// player_motion_fsm: per-player walk/crouch/jump/attack/shield engine.
// Ports: clk, rst (sync, active-high), tick, ctrl_in[6:0] ->
//   player_x, player_y, state, facing_left, attack_active,
//   shield_active, airborne. All outputs registered.
// Option: PLAYER_DOUBLE_JUMP_EN adds one mid-air jump on up rising edge.
module player_motion_fsm
  import player_motion_pkg::*;
#(
  parameter int X_W            = 10,
  parameter int Y_W            = 10,
  parameter int VY_W           = 8,
  parameter int X_INIT         = 300,
  parameter int Y_GROUND       = 300,
  parameter int Y_MIN          = 0,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 600,
  parameter int WALK_STEP      = 1,
  parameter int JUMP_V0        = 8,
  parameter int GRAVITY        = 1,
  parameter int ATTACK_TICKS   = 10,
  parameter int COOLDOWN_TICKS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [X_W-1:0]    player_x,
  output logic [Y_W-1:0]    player_y,
  output logic [2:0]        state,
  output logic              facing_left,
  output logic              attack_active,
  output logic              shield_active,
  output logic              airborne
);

  localparam int TMR_MAX =
    (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int YE_W  = Y_W + 2;

  localparam logic [X_W:0] STEP_E  = WALK_STEP[X_W:0];
  localparam logic [X_W:0] XMAX_E  = X_MAX[X_W:0];
  localparam logic [X_W:0] XLIM_E  = X_MIN[X_W:0] + WALK_STEP[X_W:0];
  localparam logic [X_W-1:0] XMAX  = X_MAX[X_W-1:0];
  localparam logic [X_W-1:0] XMIN  = X_MIN[X_W-1:0];
  localparam logic [X_W-1:0] XINIT = X_INIT[X_W-1:0];

  localparam logic signed [YE_W-1:0] YG_E   = Y_GROUND[YE_W-1:0];
  localparam logic signed [YE_W-1:0] YMIN_E = Y_MIN[YE_W-1:0];
  localparam logic [Y_W-1:0] YG   = Y_GROUND[Y_W-1:0];
  localparam logic [Y_W-1:0] YMIN = Y_MIN[Y_W-1:0];

  localparam logic signed [VY_W-1:0] VY_V0   = JUMP_V0[VY_W-1:0];
  localparam logic signed [VY_W:0]   GRAV_E  = GRAVITY[VY_W:0];
  localparam logic signed [VY_W:0]   VYMIN_E =
    {2'b11, {(VY_W-1){1'b0}}};
  localparam logic signed [VY_W-1:0] VYMIN   =
    {1'b1, {(VY_W-1){1'b0}}};

  localparam logic [TMR_W-1:0] ATK_V = ATTACK_TICKS[TMR_W-1:0];
  localparam logic [TMR_W-1:0] CD_V  = COOLDOWN_TICKS[TMR_W-1:0];

  motion_state_t state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic signed [VY_W-1:0] vy_q, vy_d;
  logic facing_q, facing_d;
  logic atk_q, shd_q, air_q;

  logic k_down, k_right, k_up, k_left, k_attack, k_shield;
  logic one_dir;

  logic [X_W:0]   x_ext, x_sum, x_diff;
  logic [X_W-1:0] x_right, x_left, x_move;

  logic signed [YE_W-1:0] y_sum;
  logic signed [VY_W:0]   vy_sub;
  logic signed [VY_W-1:0] vy_grav;
  logic land, ceil_hit;

  logic atk_load, cd_load, ground_eval;
  logic [TMR_W-1:0] atk_count, cd_count;
  logic atk_zero, cd_zero;
  logic sig_unused;

  assign k_down   = ctrl_in[CTRL_DOWN];
  assign k_right  = ctrl_in[CTRL_RIGHT];
  assign k_up     = ctrl_in[CTRL_UP];
  assign k_left   = ctrl_in[CTRL_LEFT];
  assign k_attack = ctrl_in[CTRL_ATTACK];
  assign k_shield = ctrl_in[CTRL_SHIELD];
  assign one_dir  = k_left ^ k_right;

  // One extra bit so the clamp test sees overflow/underflow.
  assign x_ext   = {1'b0, x_q};
  assign x_sum   = x_ext + STEP_E;
  assign x_diff  = x_ext - STEP_E;
  assign x_right = (x_sum > XMAX_E) ? XMAX : x_sum[X_W-1:0];
  assign x_left  = (x_ext < XLIM_E) ? XMIN : x_diff[X_W-1:0];
  assign x_move  = !one_dir ? x_q : (k_right ? x_right : x_left);

  // Screen y grows downward, so positive vy moves up.
  assign y_sum = $signed({2'b00, y_q})
               - {{(YE_W-VY_W){vy_q[VY_W-1]}}, vy_q};
  assign land     = (y_sum >= YG_E);
  assign ceil_hit = (y_sum < YMIN_E);

  assign vy_sub  = {vy_q[VY_W-1], vy_q} - GRAV_E;
  assign vy_grav = (vy_sub < VYMIN_E) ? VYMIN : vy_sub[VY_W-1:0];

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic up_prev_q, credit_q, credit_d, up_edge;

  assign up_edge = k_up & ~up_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_prev_q <= 1'b0;
      credit_q  <= 1'b1;
    end else if (tick) begin
      up_prev_q <= k_up;
      credit_q  <= credit_d;
    end
  end
`else
  // Up is ignored in the air; no edge or credit state exists.
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    facing_d    = facing_q;
    atk_load    = 1'b0;
    cd_load     = 1'b0;
    ground_eval = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    credit_d    = credit_q;
`endif
    if (tick) begin
      if (one_dir && state_q != ST_ATTACK) begin
        facing_d = k_left;
      end
      unique case (state_q)
        ST_ATTACK: begin
          if (atk_count == TMR_W'(1)) begin
            state_d = ST_IDLE;
            cd_load = 1'b1;
          end
        end
        ST_SHIELD: ground_eval = !k_shield;
        ST_AIR: begin
          x_d = x_move;
          if (land) begin
            y_d     = YG;
            vy_d    = '0;
            state_d = ST_IDLE;
          end else if (ceil_hit) begin
            y_d  = YMIN;
            vy_d = '0;
          end else begin
            y_d  = y_sum[Y_W-1:0];
            vy_d = vy_grav;
          end
`ifdef PLAYER_DOUBLE_JUMP_EN
          if (land) begin
            credit_d = 1'b1;
          end else if (up_edge && credit_q) begin
            vy_d     = VY_V0;
            credit_d = 1'b0;
          end
`else
          // Single jump only.
`endif
        end
        default: ground_eval = 1'b1;
      endcase
      if (ground_eval) begin
`ifdef PLAYER_DOUBLE_JUMP_EN
        credit_d = 1'b1;
`endif
        priority case (1'b1)
          k_attack && cd_zero: begin
            state_d  = ST_ATTACK;
            atk_load = 1'b1;
          end
          k_shield: state_d = ST_SHIELD;
          k_up: begin
            state_d = ST_AIR;
            vy_d    = VY_V0;
          end
          k_down: state_d = ST_CROUCH;
          one_dir: begin
            state_d = ST_WALK;
            x_d     = x_move;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= XINIT;
      y_q      <= YG;
      vy_q     <= '0;
      facing_q <= 1'b0;
      atk_q    <= 1'b0;
      shd_q    <= 1'b0;
      air_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
      atk_q    <= (state_d == ST_ATTACK);
      shd_q    <= (state_d == ST_SHIELD);
      air_q    <= (state_d == ST_AIR);
    end
  end

  motion_tick_timer #(.W(TMR_W)) u_atk_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .load  (atk_load),
    .value (ATK_V),
    .count (atk_count),
    .zero  (atk_zero)
  );

  motion_tick_timer #(.W(TMR_W)) u_cd_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .load  (cd_load),
    .value (CD_V),
    .count (cd_count),
    .zero  (cd_zero)
  );

  assign sig_unused = ^{ctrl_in[0], atk_zero, cd_count};

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign state         = state_q;
  assign facing_left   = facing_q;
  assign attack_active = atk_q;
  assign shield_active = shd_q;
  assign airborne      = air_q;

endmodule

// File: tb/tb_player_motion_fsm.sv
// tb_player_motion_fsm: directed-vector bench for player_motion_fsm.
// Ticks every 4 clocks; outputs sampled on the falling edge.
module tb_player_motion_fsm;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_DOWN  = 7'b0000010;
  localparam logic [6:0] C_RIGHT = 7'b0000100;
  localparam logic [6:0] C_UP    = 7'b0001000;
  localparam logic [6:0] C_LEFT  = 7'b0010000;
  localparam logic [6:0] C_ATK   = 7'b0100000;
  localparam logic [6:0] C_SHD   = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [6:0] ctrl_in = '0;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [2:0] state;
  logic       facing_left;
  logic       attack_active;
  logic       shield_active;
  logic       airborne;

  int n_checks = 0;
  int n_errors = 0;

  int y_air [17] = '{292, 285, 279, 274, 270, 267, 265, 264,
                     264, 265, 267, 270, 274, 279, 285, 292, 300};

  always #5 clk = ~clk;

  player_motion_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .ctrl_in       (ctrl_in),
    .player_x      (player_x),
    .player_y      (player_y),
    .state         (state),
    .facing_left   (facing_left),
    .attack_active (attack_active),
    .shield_active (shield_active),
    .airborne      (airborne)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_tick(input logic [6:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ctrl_in = c;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_x", player_x, 300);
    check("rst_y", player_y, 300);
    check("rst_state", state, 0);
    check("rst_facing", facing_left, 0);
    check("rst_flags", {attack_active, shield_active, airborne}, 0);

    ctrl_in = C_RIGHT;
    repeat (8) @(negedge clk);
    check("no_tick_x", player_x, 300);

    run_tick(C_RIGHT, 5);
    check("walk_x", player_x, 305);
    check("walk_state", state, 1);
    check("walk_facing", facing_left, 0);
    run_tick(C_NONE, 1);
    check("release_state", state, 0);
    check("release_x", player_x, 305);

    run_tick(C_LEFT, 1);
    check("left_x", player_x, 304);
    check("left_facing", facing_left, 1);
    run_tick(C_LEFT | C_RIGHT, 1);
    check("lr_x", player_x, 304);
    check("lr_facing", facing_left, 1);
    check("lr_state", state, 0);

    run_tick(C_UP, 1);
    check("launch_state", state, 3);
    check("launch_air", airborne, 1);
    check("launch_y", player_y, 300);
    for (int i = 0; i < 17; i++) begin
      run_tick(C_NONE, 1);
      check($sformatf("jump_y%0d", i), player_y, y_air[i]);
    end
    check("land_state", state, 0);
    check("land_air", airborne, 0);

    run_tick(C_DOWN, 1);
    check("crouch_state", state, 2);
    check("crouch_x", player_x, 304);
    run_tick(C_NONE, 1);
    check("uncrouch", state, 0);

    run_tick(C_ATK, 1);
    check("atk0_state", state, 4);
    check("atk0_active", attack_active, 1);
    for (int t = 1; t <= 10; t++) begin
      run_tick((t < 10) ? C_LEFT : C_NONE, 1);
      check($sformatf("atk_active_t%0d", t), attack_active,
            (t <= 9) ? 1 : 0);
    end
    check("atk_x_frozen", player_x, 304);
    check("atk_end_state", state, 0);
    run_tick(C_NONE, 1);
    run_tick(C_ATK, 1);
    check("cooldown_t12", state, 0);
    check("cooldown_t12_flag", attack_active, 0);
    run_tick(C_NONE, 13);
    run_tick(C_ATK, 1);
    check("reattack_t26", state, 4);
    run_tick(C_NONE, 10);
    check("reattack_end", state, 0);

    run_tick(C_LEFT | C_RIGHT | C_SHD, 3);
    check("shield_state", state, 5);
    check("shield_flag", shield_active, 1);
    check("shield_x", player_x, 304);
    run_tick(C_NONE, 1);
    check("unshield", state, 0);
    check("unshield_flag", shield_active, 0);

    run_tick(C_RIGHT, 295);
    check("x_599", player_x, 599);
    run_tick(C_RIGHT, 3);
    check("clamp_max", player_x, 600);
    check("clamp_max_state", state, 1);
    run_tick(C_LEFT, 599);
    check("x_1", player_x, 1);
    run_tick(C_LEFT, 2);
    check("clamp_min", player_x, 0);
    check("clamp_min_facing", facing_left, 1);
    run_tick(C_LEFT, 1);
    check("clamp_min_hold", player_x, 0);

    run_tick(C_UP, 1);
    run_tick(C_RIGHT, 3);
    check("air_walk_x", player_x, 3);
    check("air_walk_y", player_y, 279);
    check("air_facing", facing_left, 0);
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b1;
    ctrl_in = C_UP;
    @(negedge clk);
    rst = 1'b0;
    tick = 1'b0;
    ctrl_in = C_NONE;
    check("midjump_rst_x", player_x, 300);
    check("midjump_rst_y", player_y, 300);
    check("midjump_rst_state", state, 0);
    check("midjump_rst_air", airborne, 0);

`ifdef PLAYER_DOUBLE_JUMP_EN
    run_tick(C_UP, 1);
    run_tick(C_NONE, 8);
    check("dj_apex_y", player_y, 264);
    run_tick(C_UP, 1);
    check("dj_reload_y", player_y, 264);
    run_tick(C_NONE, 1);
    check("dj_after_y", player_y, 256);
    run_tick(C_UP, 1);
    check("dj_third_y", player_y, 249);
    run_tick(C_NONE, 1);
    check("dj_third_ignored", player_y, 243);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
